// File: rtl/alu_result_display.sv
// alu_result_display: captures an 8-bit ALU result, converts its magnitude to
// three BCD digits with an 8-step shift-add-3 loop, then time-multiplexes
// sign/hundreds/tens/ones onto a single 7-segment output.
module alu_result_display #(
  parameter int DWELL = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  result,
  input  logic        signed_mode,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  digit_en
);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  // Last dwell count before the display moves to the next position.
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      state_reg,    state_next;
  logic [19:0] shift_reg,    shift_next;     // {hundreds, tens, ones, mag}
  logic [2:0]  iter_reg,     iter_next;
  logic        neg_pend_reg, neg_pend_next;  // sign of operand being converted
  logic [11:0] bcd_reg,      bcd_next;
  logic        neg_reg,      neg_next;
  logic        done_reg,     done_next;
  logic [1:0]  pos_reg,      pos_next;       // 0 ones, 1 tens, 2 hundreds, 3 sign
  logic [15:0] dwell_reg,    dwell_next;

  // Operand magnitude and sign as seen at the capture edge.
  logic       load_neg;
  logic [7:0] load_mag;
  assign load_neg = signed_mode & result[7];
  assign load_mag = load_neg ? (~result + 8'd1) : result;

  // One shift-add-3 step: correct each BCD digit that is 5 or more, then shift.
  logic [19:0] adj;
  logic [19:0] shift_step;
  assign adj[7:0] = shift_reg[7:0];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] dig;
      assign dig = shift_reg[8 + 4*gi +: 4];
      assign adj[8 + 4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
  endgenerate
  assign shift_step = adj << 1;

  // BCD digit to segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Glyph per display position, with leading-zero blanking applied.
  logic [6:0] raw_glyph [3];
  logic [6:0] pos_glyph [4];
  logic [3:0] pos_onehot;
  logic       hun_zero;
  logic       ten_zero;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_raw
      assign raw_glyph[gi] = seg7(bcd_reg[4*gi +: 4]);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign pos_onehot[gi] = (pos_reg == 2'(gi));
    end
  endgenerate
  assign hun_zero     = (bcd_reg[11:8] == 4'd0);
  assign ten_zero     = (bcd_reg[7:4] == 4'd0);
  assign pos_glyph[0] = raw_glyph[0];
  assign pos_glyph[1] = (hun_zero && ten_zero) ? 7'h00 : raw_glyph[1];
  assign pos_glyph[2] = hun_zero ? 7'h00 : raw_glyph[2];
  assign pos_glyph[3] = neg_reg ? 7'h40 : 7'h00;

  // State register; asynchronous reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      iter_reg     <= '0;
      neg_pend_reg <= 1'b0;
      bcd_reg      <= '0;
      neg_reg      <= 1'b0;
      done_reg     <= 1'b0;
      pos_reg      <= '0;
      dwell_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      iter_reg     <= iter_next;
      neg_pend_reg <= neg_pend_next;
      bcd_reg      <= bcd_next;
      neg_reg      <= neg_next;
      done_reg     <= done_next;
      pos_reg      <= pos_next;
      dwell_reg    <= dwell_next;
    end
  end

  // Next-state: capture outside CONV, iterate in CONV, rotate positions in SHOW.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    iter_next     = iter_reg;
    neg_pend_next = neg_pend_reg;
    bcd_next      = bcd_reg;
    neg_next      = neg_reg;
    done_next     = 1'b0;
    pos_next      = pos_reg;
    dwell_next    = dwell_reg;
    if (state_reg != CONV && load) begin
      // A load at a dwell boundary wins over the position advance.
      state_next    = CONV;
      shift_next    = {12'd0, load_mag};
      iter_next     = 3'd0;
      neg_pend_next = load_neg;
    end else begin
      case (state_reg)
        CONV: begin
          shift_next = shift_step;
          iter_next  = iter_reg + 3'd1;
          if (iter_reg == 3'd7) begin
            state_next = SHOW;
            bcd_next   = shift_step[19:8];
            neg_next   = neg_pend_reg;
            done_next  = 1'b1;
            pos_next   = 2'd0;
            dwell_next = 16'd0;
          end
        end
        SHOW: begin
          if (dwell_reg == DWELL_LAST) begin
            dwell_next = 16'd0;
            pos_next   = pos_reg + 2'd1;
          end else begin
            dwell_next = dwell_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display drive: dark while idle or converting, one position at a time in SHOW.
  always_comb begin
    seg      = 7'h00;
    digit_en = 4'b0000;
    if (state_reg == SHOW) begin
      seg      = pos_glyph[pos_reg];
      digit_en = pos_onehot;
    end
  end

  assign busy = (state_reg == CONV);
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign neg  = neg_reg;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized self-checking bench for alu_result_display against an
// arithmetic model (divide/modulo for BCD, position = cycle / DWELL mod 4).
module tb_alu_result_display;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  result;
  logic        signed_mode;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        neg;
  logic [6:0]  seg;
  logic [3:0]  digit_en;

  int errors = 0;
  int checks = 0;

  // Reference model state for the operand currently expected on the display.
  logic [11:0] exp_bcd;
  logic        exp_neg;
  int          eh, et, eo;

  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  alu_result_display #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .result      (result),
    .signed_mode (signed_mode),
    .load        (load),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .neg         (neg),
    .seg         (seg),
    .digit_en    (digit_en)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_model(input logic [7:0] r, input logic sm);
    int m;
    if (sm && r[7]) begin
      m       = 256 - int'(r);
      exp_neg = 1'b1;
    end else begin
      m       = int'(r);
      exp_neg = 1'b0;
    end
    eh      = m / 100;
    et      = (m / 10) % 10;
    eo      = m % 10;
    exp_bcd = {4'(eh), 4'(et), 4'(eo)};
  endtask

  function automatic logic [6:0] exp_seg(input int p);
    case (p)
      0:       exp_seg = GLYPH[eo];
      1:       exp_seg = (eh == 0 && et == 0) ? 7'h00 : GLYPH[et];
      2:       exp_seg = (eh == 0) ? 7'h00 : GLYPH[eh];
      default: exp_seg = exp_neg ? 7'h40 : 7'h00;
    endcase
  endfunction

  // c = cycles since the done edge.
  task automatic check_show(input int c);
    int p;
    p = (c / DWELL) % 4;
    check("digit_en", 32'(digit_en), 32'(1) << p);
    check("seg", 32'(seg), 32'(exp_seg(p)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_bcd"}, 32'(bcd), 0);
    check({tag, "_neg"}, 32'(neg), 0);
    check({tag, "_seg"}, 32'(seg), 0);
    check({tag, "_digit_en"}, 32'(digit_en), 0);
  endtask

  // Called #1 after an edge: load the operand, follow the 8 conversion
  // cycles, then check show_cycles cycles of display.
  task automatic run_conv(input logic [7:0] r, input logic sm, input bit pulse_e3,
                          input int show_cycles);
    result      = r;
    signed_mode = sm;
    load        = 1'b1;
    set_model(r, sm);
    @(posedge clk); #1;
    load        = 1'b0;
    result      = ~r;
    signed_mode = ~sm;
    for (int i = 0; i < 8; i++) begin
      check("conv_busy", 32'(busy), 1);
      check("conv_done", 32'(done), 0);
      check("conv_digit_en", 32'(digit_en), 0);
      check("conv_seg", 32'(seg), 0);
      if (pulse_e3 && i == 2) load = 1'b1;
      if (i == 3) load = 1'b0;
      @(posedge clk); #1;
    end
    check("done_busy", 32'(busy), 0);
    check("done_pulse", 32'(done), 1);
    check("bcd", 32'(bcd), 32'(exp_bcd));
    check("neg", 32'(neg), 32'(exp_neg));
    check_show(0);
    $display("conv result=0x%02h signed=%0d -> bcd=0x%03h neg=%0d (model 0x%03h %0d)",
             r, sm, bcd, neg, exp_bcd, exp_neg);
    for (int c = 1; c < show_cycles; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("done_clear", 32'(done), 0);
      check("hold_bcd", 32'(bcd), 32'(exp_bcd));
      check_show(c);
    end
  endtask

  initial begin
    rst         = 1'b1;
    load        = 1'b0;
    result      = 8'h00;
    signed_mode = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases; each following load lands on a position-advance edge.
    run_conv(8'hFF, 1'b0, 1'b0, 8 * DWELL);
    run_conv(8'hF1, 1'b1, 1'b0, 4 * DWELL);
    run_conv(8'h00, 1'b0, 1'b0, 4 * DWELL);
    run_conv(8'h80, 1'b1, 1'b0, 4 * DWELL);
    run_conv(8'h00, 1'b1, 1'b0, 4 * DWELL);
    run_conv(8'h7F, 1'b1, 1'b0, 4 * DWELL);
    // Load pulsed during CONV is ignored.
    run_conv(8'h2A, 1'b0, 1'b1, 4 * DWELL);

    // Asynchronous reset while displaying.
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_show");
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset in the middle of a conversion.
    result      = 8'hC8;
    signed_mode = 1'b0;
    load        = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_conv");
    @(posedge clk); #1;
    rst = 1'b0;
    run_conv(8'hC8, 1'b1, 1'b0, 4 * DWELL);

    // Randomized operands with random display lengths.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] r;
      logic       sm;
      r  = 8'($urandom);
      sm = 1'($urandom);
      run_conv(r, sm, 1'($urandom_range(0, 3) == 0), $urandom_range(1, 20));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
